// File: rtl/mips_pkg.sv
// Shared definitions for the multi-cycle MIPS control path: FSM states,
// opcode/funct constants, ALUOp encodings and the control-word layout.
package mips_pkg;

    typedef enum logic [3:0] {
        FETCH,
        DECODE,
        MEM_ADDR,
        MEM_RD,
        MEM_WB,
        MEM_WR,
        EXEC_R,
        R_WB,
        EXEC_I,
        I_WB,
        BRANCH,
        JUMP,
        JAL,
        JR,
        TRAP
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_JR    = 6'h08;

    // Encodings understood by ALUControl
    typedef enum logic [2:0] {
        ALU_ADD   = 3'd0,
        ALU_SUB   = 3'd1,
        ALU_RTYPE = 3'd2,
        ALU_ADDI  = 3'd3,
        ALU_ANDI  = 3'd4,
        ALU_ORI   = 3'd5,
        ALU_LUI   = 3'd6,
        ALU_PASSA = 3'd7
    } alu_op_t;

    // One-hot instruction class produced by the opcode decoder
    typedef struct packed {
        logic is_mem;
        logic is_rtype;
        logic is_jr;
        logic is_imm;
        logic is_branch;
        logic is_jump;
        logic is_jal;
        logic is_illegal;
    } op_class_t;

    // Registered control word. 'fetch' and 'branch' are qualifiers that are
    // combined with mem_ready / zero at the output, since those inputs must
    // act in the same cycle they are presented.
    typedef struct packed {
        logic       fetch;
        logic       branch;
        logic       pc_write;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic [1:0] reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        alu_op_t    alu_op;
        logic [1:0] pc_source;
    } ctrl_t;

    // ALU operation for the immediate-arithmetic group
    function automatic alu_op_t imm_alu_op(input logic [5:0] op);
        alu_op_t r;
        case (op)
            OP_ANDI: r = ALU_ANDI;
            OP_ORI:  r = ALU_ORI;
            OP_LUI:  r = ALU_LUI;
            default: r = ALU_ADDI;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mips_opcode_decode.sv
// Combinational instruction-class decoder used when the FSM dispatches
// out of DECODE. Exactly one class bit is set for any opcode/funct pair.
module mips_opcode_decode
    import mips_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output op_class_t  op_class
);

    // Classify the opcode; unknown opcodes fall into the illegal class
    always_comb begin
        op_class = '0;
        case (opcode)
            OP_LW, OP_SW: op_class.is_mem = 1'b1;
            OP_RTYPE: begin
                if (funct == FN_JR) op_class.is_jr    = 1'b1;
                else                op_class.is_rtype = 1'b1;
            end
            OP_ADDI, OP_ANDI, OP_ORI, OP_LUI: op_class.is_imm = 1'b1;
            OP_BEQ, OP_BNE: op_class.is_branch = 1'b1;
            OP_J:           op_class.is_jump   = 1'b1;
            OP_JAL:         op_class.is_jal    = 1'b1;
            default:        op_class.is_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_control.sv
// Multi-cycle MIPS sequencing controller. The control word for each state
// is computed from the next state and registered, so every select and
// enable comes straight from a flop; only the memory-handshake writes and
// the branch condition are qualified combinationally.
module mips_multicycle_control
    import mips_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             PCWrite,
    output logic             PCWriteCond,
    output logic             IorD,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             MemtoReg,
    output logic [1:0]       RegDst,
    output logic             RegWrite,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [2:0]       ALUOp,
    output logic [1:0]       PCSource,
    output logic             illegal,
    output logic [CNT_W-1:0] instr_count
);

    state_t           state_q;
    state_t           state_d;
    ctrl_t            ctrl_q;
    ctrl_t            ctrl_d;
    op_class_t        op_class;
    logic [5:0]       op_q;
    logic [5:0]       op_eff;
    logic             illegal_q;
    logic [CNT_W-1:0] instr_count_q;

    mips_opcode_decode u_decode (
        .opcode   (opcode),
        .funct    (funct),
        .op_class (op_class)
    );

    function automatic state_t next_state(input state_t    s,
                                          input op_class_t c,
                                          input logic [5:0] op,
                                          input logic      rdy);
        state_t n;
        n = s;
        case (s)
            FETCH:    n = rdy ? DECODE : FETCH;
            DECODE: begin
                if      (c.is_illegal) n = TRAP;
                else if (c.is_mem)     n = MEM_ADDR;
                else if (c.is_jr)      n = JR;
                else if (c.is_rtype)   n = EXEC_R;
                else if (c.is_imm)     n = EXEC_I;
                else if (c.is_branch)  n = BRANCH;
                else if (c.is_jump)    n = JUMP;
                else                   n = JAL;
            end
            MEM_ADDR: n = (op == OP_LW) ? MEM_RD : MEM_WR;
            MEM_RD:   n = rdy ? MEM_WB : MEM_RD;
            MEM_WR:   n = rdy ? FETCH : MEM_WR;
            EXEC_R:   n = R_WB;
            EXEC_I:   n = I_WB;
            TRAP:     n = TRAP;
            default:  n = FETCH;
        endcase
        return n;
    endfunction

    function automatic ctrl_t ctrl_for(input state_t s, input logic [5:0] op);
        ctrl_t c;
        c = '0;
        case (s)
            FETCH: begin
                c.fetch     = 1'b1;
                c.mem_read  = 1'b1;
                c.alu_src_b = 2'd1;
                c.alu_op    = ALU_ADD;
            end
            DECODE: begin
                c.alu_src_b = 2'd3;
                c.alu_op    = ALU_ADD;
            end
            MEM_ADDR: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'd2;
                c.alu_op    = ALU_ADD;
            end
            MEM_RD: begin
                c.iord     = 1'b1;
                c.mem_read = 1'b1;
            end
            MEM_WB: begin
                c.mem_to_reg = 1'b1;
                c.reg_write  = 1'b1;
            end
            MEM_WR: begin
                c.iord      = 1'b1;
                c.mem_write = 1'b1;
            end
            EXEC_R: begin
                c.alu_src_a = 1'b1;
                c.alu_op    = ALU_RTYPE;
            end
            R_WB: begin
                c.reg_dst   = 2'd1;
                c.reg_write = 1'b1;
            end
            EXEC_I: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'd2;
                c.alu_op    = imm_alu_op(op);
            end
            I_WB: c.reg_write = 1'b1;
            BRANCH: begin
                c.branch    = 1'b1;
                c.alu_src_a = 1'b1;
                c.alu_op    = ALU_SUB;
                c.pc_source = 2'd1;
            end
            JUMP: begin
                c.pc_write  = 1'b1;
                c.pc_source = 2'd2;
            end
            JAL: begin
                c.pc_write  = 1'b1;
                c.pc_source = 2'd2;
                c.reg_dst   = 2'd2;
                c.reg_write = 1'b1;
                c.alu_op    = ALU_PASSA;
            end
            JR: begin
                c.pc_write  = 1'b1;
                c.pc_source = 2'd3;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    // The live opcode is only trusted in DECODE; later states use the latched copy
    assign op_eff = (state_q == DECODE) ? opcode : op_q;

    // Next state and the control word that state will present
    always_comb begin
        state_d = next_state(state_q, op_class, op_eff, mem_ready);
        ctrl_d  = ctrl_for(state_d, op_eff);
    end

    // FSM: state, registered control word, sticky trap flag, retire counter
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= FETCH;
            ctrl_q        <= ctrl_for(FETCH, OP_RTYPE);
            illegal_q     <= 1'b0;
            instr_count_q <= '0;
        end else begin
            state_q <= state_d;
            ctrl_q  <= ctrl_d;
            if (state_d == TRAP)
                illegal_q <= 1'b1;
            if ((state_q != FETCH) && (state_d == FETCH))
                instr_count_q <= instr_count_q + 1'b1;
        end
    end

    // Latch the opcode once, when the instruction is dispatched
    always_ff @(posedge clk) begin
        if (state_q == DECODE)
            op_q <= opcode;
    end

    assign IRWrite     = ctrl_q.fetch & mem_ready;
    assign PCWrite     = ctrl_q.pc_write | (ctrl_q.fetch & mem_ready);
    assign PCWriteCond = ctrl_q.branch &
                         (((op_q == OP_BEQ) & zero) | ((op_q == OP_BNE) & ~zero));
    assign IorD        = ctrl_q.iord;
    assign MemRead     = ctrl_q.mem_read;
    assign MemWrite    = ctrl_q.mem_write;
    assign MemtoReg    = ctrl_q.mem_to_reg;
    assign RegDst      = ctrl_q.reg_dst;
    assign RegWrite    = ctrl_q.reg_write;
    assign ALUSrcA     = ctrl_q.alu_src_a;
    assign ALUSrcB     = ctrl_q.alu_src_b;
    assign ALUOp       = ctrl_q.alu_op;
    assign PCSource    = ctrl_q.pc_source;
    assign illegal     = illegal_q;
    assign instr_count = instr_count_q;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Directed bench for the multi-cycle MIPS controller. Inputs change on the
// falling edge; outputs are checked 1 ns later, well away from the rising edge.
module tb_mips_multicycle_control;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic        zero;
    logic        mem_ready;
    logic        PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
    logic        MemtoReg, RegWrite, ALUSrcA, illegal;
    logic [1:0]  RegDst, ALUSrcB, PCSource;
    logic [2:0]  ALUOp;
    logic [31:0] instr_count;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mips_multicycle_control #(.CNT_W(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .opcode      (opcode),
        .funct       (funct),
        .zero        (zero),
        .mem_ready   (mem_ready),
        .PCWrite     (PCWrite),
        .PCWriteCond (PCWriteCond),
        .IorD        (IorD),
        .MemRead     (MemRead),
        .MemWrite    (MemWrite),
        .IRWrite     (IRWrite),
        .MemtoReg    (MemtoReg),
        .RegDst      (RegDst),
        .RegWrite    (RegWrite),
        .ALUSrcA     (ALUSrcA),
        .ALUSrcB     (ALUSrcB),
        .ALUOp       (ALUOp),
        .PCSource    (PCSource),
        .illegal     (illegal),
        .instr_count (instr_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to the next falling edge (one full clock cycle)
    task automatic next_cycle();
        @(negedge clk);
    endtask

    // Drive mem_ready for the current cycle and let outputs settle
    task automatic drive(input logic rdy);
        mem_ready = rdy;
        #1;
    endtask

    initial begin
        reset = 1'b1; opcode = 6'h00; funct = 6'h00; zero = 1'b0; mem_ready = 1'b0;
        next_cycle();
        next_cycle();
        reset = 1'b0;

        // Reset state: FETCH outputs, counters cleared
        drive(1'b0);
        chk("rst_memread", MemRead, 1);
        chk("rst_iord", IorD, 0);
        chk("rst_alusrcb", ALUSrcB, 1);
        chk("rst_irwrite_wait", IRWrite, 0);
        chk("rst_pcwrite_wait", PCWrite, 0);
        chk("rst_illegal", illegal, 0);
        chk("rst_count", instr_count, 0);

        // lw, two wait cycles on each memory access
        opcode = 6'h23;
        next_cycle(); drive(1'b0);
        chk("lw_f2_irwrite", IRWrite, 0);
        chk("lw_f2_memread", MemRead, 1);
        next_cycle(); drive(1'b1);
        chk("lw_f3_irwrite", IRWrite, 1);
        chk("lw_f3_pcwrite", PCWrite, 1);
        next_cycle(); drive(1'b0);
        chk("lw_dec_alusrcb", ALUSrcB, 3);
        chk("lw_dec_memread", MemRead, 0);
        next_cycle(); drive(1'b0);
        chk("lw_addr_srca", ALUSrcA, 1);
        chk("lw_addr_srcb", ALUSrcB, 2);
        next_cycle(); drive(1'b0);
        chk("lw_rd1_iord", IorD, 1);
        chk("lw_rd1_memread", MemRead, 1);
        next_cycle(); drive(1'b0);
        chk("lw_rd2_stable", {IorD, MemRead}, 2'b11);
        next_cycle(); drive(1'b1);
        chk("lw_rd3_regwrite", RegWrite, 0);
        next_cycle(); drive(1'b0);
        chk("lw_wb_regwrite", RegWrite, 1);
        chk("lw_wb_memtoreg", MemtoReg, 1);
        chk("lw_wb_regdst", RegDst, 0);
        chk("lw_wb_count", instr_count, 0);
        next_cycle();

        // add: IRWrite in cycle 1, RegWrite with RegDst=1 only in cycle 4
        opcode = 6'h00; funct = 6'h20;
        drive(1'b1);
        chk("lw_retired", instr_count, 1);
        chk("add_c1_irwrite", IRWrite, 1);
        chk("add_c1_regwrite", RegWrite, 0);
        next_cycle(); drive(1'b1);
        chk("add_c2_regwrite", RegWrite, 0);
        next_cycle(); drive(1'b1);
        chk("add_c3_aluop", ALUOp, 2);
        chk("add_c3_srcs", {ALUSrcA, ALUSrcB}, 3'b100);
        chk("add_c3_regwrite", RegWrite, 0);
        next_cycle(); drive(1'b1);
        chk("add_c4_regwrite", RegWrite, 1);
        chk("add_c4_regdst", RegDst, 1);
        chk("add_c4_memtoreg", MemtoReg, 0);
        next_cycle();

        // beq with zero=1: branch taken; later IR changes are ignored
        opcode = 6'h04; funct = 6'h00; zero = 1'b1;
        drive(1'b1);
        chk("add_retired", instr_count, 2);
        chk("add_next_regwrite", RegWrite, 0);
        next_cycle(); drive(1'b1);
        chk("beq_dec_pcwc", PCWriteCond, 0);
        next_cycle(); drive(1'b1);
        chk("beq_pcwc", PCWriteCond, 1);
        chk("beq_pcsource", PCSource, 1);
        chk("beq_aluop", ALUOp, 1);
        opcode = 6'h05; #1;
        chk("beq_ir_change", PCWriteCond, 1);
        zero = 1'b0; #1;
        chk("beq_not_zero", PCWriteCond, 0);
        next_cycle();

        // bne with zero=1: not taken
        opcode = 6'h05; zero = 1'b1;
        drive(1'b1);
        chk("beq_retired", instr_count, 3);
        next_cycle(); drive(1'b1);
        next_cycle(); drive(1'b1);
        chk("bne_pcwc", PCWriteCond, 0);
        chk("bne_pcsource", PCSource, 1);
        next_cycle();
        zero = 1'b0;

        // jal: link and jump in the same cycle
        opcode = 6'h03;
        drive(1'b1);
        chk("bne_retired", instr_count, 4);
        next_cycle(); drive(1'b1);
        next_cycle(); drive(1'b1);
        chk("jal_ctrl", {PCWrite, PCSource, RegDst, RegWrite}, 6'b1_10_10_1);
        chk("jal_aluop", ALUOp, 7);
        chk("jal_srcs", {ALUSrcA, ALUSrcB, MemtoReg}, 4'b0000);
        next_cycle();

        // jr
        opcode = 6'h00; funct = 6'h08;
        drive(1'b1);
        chk("jal_retired", instr_count, 5);
        next_cycle(); drive(1'b1);
        next_cycle(); drive(1'b1);
        chk("jr_pcwrite", PCWrite, 1);
        chk("jr_pcsource", PCSource, 3);
        chk("jr_regwrite", RegWrite, 0);
        next_cycle();

        // sw with one wait cycle
        opcode = 6'h2B; funct = 6'h00;
        drive(1'b1);
        chk("jr_retired", instr_count, 6);
        next_cycle(); drive(1'b1);
        next_cycle(); drive(1'b1);
        chk("sw_addr_srcb", ALUSrcB, 2);
        next_cycle(); drive(1'b0);
        chk("sw_wr1", {IorD, MemWrite, MemRead}, 3'b110);
        next_cycle(); drive(1'b1);
        chk("sw_wr2", {IorD, MemWrite}, 2'b11);
        next_cycle();

        // Unsupported opcode traps and stays trapped
        opcode = 6'h3F;
        drive(1'b1);
        chk("sw_retired", instr_count, 7);
        chk("sw_done_memwrite", MemWrite, 0);
        next_cycle(); drive(1'b1);
        chk("trap_dec_illegal", illegal, 0);
        next_cycle();
        for (int i = 0; i < 10; i++) begin
            drive(1'b1);
            chk("trap_illegal", illegal, 1);
            chk("trap_enables",
                {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, RegWrite, MemtoReg}, 0);
            next_cycle();
        end
        drive(1'b1);
        chk("trap_count", instr_count, 7);
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
        drive(1'b0);
        chk("trap_rst_illegal", illegal, 0);
        chk("trap_rst_fetch", {MemRead, IorD}, 2'b10);
        chk("trap_rst_count", instr_count, 0);

        // Counter wrap: preload all-ones, retire a jump
        force dut.instr_count_q = 32'hFFFF_FFFF;
        #1;
        release dut.instr_count_q;
        #1;
        chk("wrap_preload", instr_count, 32'hFFFF_FFFF);
        opcode = 6'h02;
        drive(1'b1);
        next_cycle(); drive(1'b1);
        next_cycle(); drive(1'b1);
        chk("j_ctrl", {PCWrite, PCSource}, 3'b1_10);
        next_cycle(); drive(1'b0);
        chk("wrap_count", instr_count, 0);

        // Reset during MEM_WR abandons the store
        opcode = 6'h2B;
        drive(1'b1);
        next_cycle(); drive(1'b1);
        next_cycle(); drive(1'b1);
        next_cycle(); drive(1'b0);
        chk("swr_memwrite", MemWrite, 1);
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
        drive(1'b0);
        chk("swr_no_memwrite", MemWrite, 0);
        chk("swr_fetch", MemRead, 1);
        chk("swr_count", instr_count, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mips_multicycle_control.md
# mips_multicycle_control

Sequencing controller that turns the team's MIPS datapath into a multi-cycle machine: one shared memory port for instruction fetch and data, one ALU reused for PC increment, branch target and execute. The block decodes the opcode and funct fields once per instruction, walks a state machine through fetch/decode/execute/memory/write-back, and drives every datapath select and write enable. It waits on a memory-ready handshake and traps on unsupported opcodes. It also keeps a retired-instruction counter for the processor's status output.

## Interface
Parameters:
- CNT_W, 32, width of retired-instruction counter

Ports:
- clk  in  1  system clock
- reset  in  1  reset; **synchronous, active-high**
- opcode  in  6  instruction[31:26], taken from the instruction register
- funct  in  6  instruction[5:0]
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes the current read/write this cycle
- PCWrite  out  1  unconditional PC load
- PCWriteCond  out  1  PC load if branch condition holds (resolved internally; see Operation)
- IorD  out  1  memory address select: 0 = PC, 1 = ALUOut
- MemRead  out  1  memory read request
- MemWrite  out  1  memory write request
- IRWrite  out  1  instruction register load
- MemtoReg  out  1  write-back data: 0 = ALUOut, 1 = MDR
- RegDst  out  2  write register select: 0 = rt, 1 = rd, 2 = 31
- RegWrite  out  1  register file write
- ALUSrcA  out  1  0 = PC, 1 = rs
- ALUSrcB  out  2  0 = rt, 1 = constant 4, 2 = sign-ext imm, 3 = sign-ext imm << 2
- ALUOp  out  3  to ALUControl
- PCSource  out  2  0 = ALU result, 1 = ALUOut (branch target), 2 = jump target, 3 = rs (jr)
- illegal  out  1  sticky trap flag
- instr_count  out  CNT_W  retired instructions

## Operation
- States: FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, EXEC_R, R_WB, EXEC_I, I_WB, BRANCH, JUMP, JAL, JR, TRAP.
- FETCH: IorD=0, MemRead=1, ALUSrcA=0, ALUSrcB=1, ALUOp=ADD, PCSource=0. IRWrite=1 and PCWrite=1 only in the cycle mem_ready=1; then go to DECODE. Otherwise hold.
- DECODE: ALUSrcA=0, ALUSrcB=3, ALUOp=ADD (branch target into ALUOut). Dispatch on opcode:
  - 0x23/0x2B → MEM_ADDR
  - 0x00 with funct 0x08 → JR; other 0x00 → EXEC_R
  - 0x08/0x0C/0x0D/0x0F → EXEC_I
  - 0x04/0x05 → BRANCH
  - 0x02 → JUMP
  - 0x03 → JAL
  - anything else → TRAP
- MEM_ADDR: ALUSrcA=1, ALUSrcB=2, ALUOp=ADD. lw → MEM_RD; sw → MEM_WR.
- MEM_RD: IorD=1, MemRead=1. Hold until mem_ready, then MEM_WB.
- MEM_WB: RegDst=0, MemtoReg=1, RegWrite=1. Then FETCH.
- MEM_WR: IorD=1, MemWrite=1. Hold until mem_ready, then FETCH.
- EXEC_R: ALUSrcA=1, ALUSrcB=0, ALUOp=RTYPE. Then R_WB.
- R_WB: RegDst=1, MemtoReg=0, RegWrite=1. Then FETCH.
- EXEC_I: ALUSrcA=1, ALUSrcB=2, ALUOp per opcode (ADDI/ANDI/ORI/LUI). Then I_WB.
- I_WB: RegDst=0, RegWrite=1. Then FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=0, ALUOp=SUB, PCSource=1. PCWriteCond=1 when (beq & zero) | (bne & ~zero). Then FETCH.
- JUMP: PCWrite=1, PCSource=2. Then FETCH.
- JAL: PCWrite=1, PCSource=2, RegDst=2, RegWrite=1. Write-back data is PC (already PC+4), selected by ALUSrcA=0, ALUSrcB=0 with ALUOp=PASSA and MemtoReg=0. Then FETCH.
- JR: PCWrite=1, PCSource=3. Then FETCH.
- TRAP: all enables 0, illegal=1. Exits only on reset.
- Any output not listed for a state is 0.
- instr_count increments by 1 on every transition into FETCH from a non-FETCH state. Wraps modulo 2^CNT_W.

## Timing
- Reset: state=FETCH, instr_count=0, illegal=0. Outputs take their FETCH values in the first cycle after reset. Reset mid-instruction abandons the instruction with no write.
- Latency in cycles, excluding memory wait: R/I-type 4, lw 5, sw 4, beq/bne 3, j/jal/jr 3.
- Each mem_ready=0 cycle in FETCH, MEM_RD or MEM_WR adds one cycle. While waiting, MemRead/MemWrite stay asserted and address selects stay stable.
- mem_ready is ignored in all other states.
- The opcode is sampled only in DECODE and is registered internally for later states; IR changes afterwards have no effect.

## Structure
- Shared package (mips_pkg): state enum, opcode/funct constants, and ALUOp encodings matching ALUControl (ADD, SUB, RTYPE, ADDI, ANDI, ORI, LUI, PASSA).
- One natural sub-module: mips_opcode_decode, a combinational class decoder (memory/rtype/jr/imm/branch/jump/jal/illegal) used by DECODE.

## Test plan
- Reset, then lw with mem_ready low 2 cycles per access → FETCH 3 cycles, MEM_RD 3 cycles, RegWrite with MemtoReg=1 on cycle 9, instr_count=1.
- add (opcode 0, funct 0x20), mem_ready=1 → IRWrite cycle 1; RegWrite with RegDst=1 in cycle 4 only.
- beq with zero=1 → PCWriteCond=1 in BRANCH. bne with zero=1 → PCWriteCond=0. Both retire in 3 cycles.
- jal → PCWrite, PCSource=2, RegDst=2, RegWrite=1 in the same cycle. jr (funct 0x08) → PCSource=3, no RegWrite.
- opcode 0x3F → TRAP, illegal=1, all enables 0 for 10 cycles, instr_count unchanged. Reset clears illegal and returns to FETCH.
- Preload instr_count to all-ones (force), retire one instruction → wraps to 0. Reset asserted mid MEM_WR → no MemWrite the following cycle.
